// File: rtl/mem_view_sequencer.sv
// Data-memory viewer sequencer: arbitrates the DataMemory read port between the CPU and the
// 7-segment display path, then walks a window of words after a finish request, latching the
// low 16 bits of each word for the scan driver.
module mem_view_sequencer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0004,
   parameter int unsigned WORD_COUNT = 16,
   parameter int unsigned DWELL      = 1000,
   parameter bit          WRAP       = 1'b1
) (
   input  logic        clk_1k,
   input  logic        reset,
   input  logic        finish_btn,
   input  logic        step_btn,
   input  logic        auto_mode,
   input  logic        pause,
   input  logic        cpu_mem_wr,
   input  logic [31:0] mem_rd_data,
   output logic        disp_sel,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   output logic [15:0] disp_word,
   output logic [15:0] word_idx,
   output logic        at_end,
   output logic        collision
);

   typedef enum logic [2:0] {StIdle, StFetch, StCapture, StShow, StHalt} state_e;

   localparam logic [15:0] LastIdx   = 16'(WORD_COUNT - 1);
   localparam logic [31:0] DwellLast = 32'(DWELL - 1);

   state_e      state_q, state_d;
   logic [15:0] word_idx_q, word_idx_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [15:0] disp_word_q, disp_word_d;
   logic [31:0] dwell_q, dwell_d;
   logic        collision_q;
   logic [2:0]  fin_sync_q;
   logic [2:0]  step_sync_q;
   logic        fin_p;
   logic        step_p;
   logic        advance;

   // Only the low half of each word is displayed.
   logic        unused_rd_hi;
   assign unused_rd_hi = ^mem_rd_data[31:16];

   // Two-flop synchronisers plus a history flop for rising-edge detection.
   always_ff @(posedge clk_1k or posedge reset) begin
      if (reset) begin
         fin_sync_q  <= 3'b000;
         step_sync_q <= 3'b000;
      end else begin
         fin_sync_q  <= {fin_sync_q[1:0], finish_btn};
         step_sync_q <= {step_sync_q[1:0], step_btn};
      end
   end

   assign fin_p  = fin_sync_q[1] & ~fin_sync_q[2];
   assign step_p = step_sync_q[1] & ~step_sync_q[2];

   // Sequencer state and datapath registers.
   always_ff @(posedge clk_1k or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         word_idx_q  <= 16'd0;
         mem_addr_q  <= BASE_ADDR;
         disp_word_q <= 16'd0;
         dwell_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         mem_addr_q  <= mem_addr_d;
         disp_word_q <= disp_word_d;
         dwell_q     <= dwell_d;
      end
   end

   // Sticky flag: a CPU write landed while the display owned the port.
   always_ff @(posedge clk_1k or posedge reset) begin
      if (reset) begin
         collision_q <= 1'b0;
      end else if (cpu_mem_wr && disp_sel) begin
         collision_q <= 1'b1;
      end
   end

   // Next-state logic; a finish pulse restarts the walk and outranks any advance.
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      mem_addr_d  = mem_addr_q;
      disp_word_d = disp_word_q;
      dwell_d     = dwell_q;
      advance     = 1'b0;

      if (state_q == StShow) begin
         if (auto_mode) begin
            if (!pause) begin
               if (dwell_q == DwellLast) begin
                  advance = 1'b1;
               end else begin
                  dwell_d = dwell_q + 32'd1;
               end
            end
         end else begin
            advance = step_p;
         end
      end

      if (fin_p) begin
         state_d    = StFetch;
         word_idx_d = 16'd0;
         mem_addr_d = BASE_ADDR;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StFetch: begin
               state_d = StCapture;
            end
            StCapture: begin
               disp_word_d = mem_rd_data[15:0];
               dwell_d     = 32'd0;
               state_d     = StShow;
            end
            StShow: begin
               if (advance) begin
                  if (word_idx_q < LastIdx) begin
                     word_idx_d = word_idx_q + 16'd1;
                     mem_addr_d = mem_addr_q + 32'd4;
                     state_d    = StFetch;
                  end else if (WRAP) begin
                     word_idx_d = 16'd0;
                     mem_addr_d = BASE_ADDR;
                     state_d    = StFetch;
                  end else begin
                     state_d = StHalt;
                  end
               end
            end
            StHalt: begin
               state_d = StHalt;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Port grant, read strobe and end-of-window flag decoded from state.
   always_comb begin
      disp_sel = (state_q != StIdle);
      mem_rd   = (state_q == StFetch) || (state_q == StCapture);
      at_end   = ((state_q == StCapture) || (state_q == StShow) || (state_q == StHalt)) &&
                 (word_idx_q == LastIdx);
   end

   assign mem_addr  = mem_addr_q;
   assign disp_word = disp_word_q;
   assign word_idx  = word_idx_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_mem_view_sequencer.sv
// Directed bench for mem_view_sequencer: a wrapping instance and a halting instance share
// stimulus; each has its own combinational memory model.
module tb_mem_view_sequencer;

   logic        clk_1k;
   logic        reset;
   logic        finish_btn;
   logic        step_btn;
   logic        auto_mode;
   logic        pause;
   logic        cpu_mem_wr;

   logic [31:0] mem_rd_data_w, mem_addr_w, mem_rd_data_h, mem_addr_h;
   logic        disp_sel_w, mem_rd_w, at_end_w, collision_w;
   logic        disp_sel_h, mem_rd_h, at_end_h, collision_h;
   logic [15:0] disp_word_w, word_idx_w, disp_word_h, word_idx_h;

   int tests_run;
   int tests_failed;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'd4:   mem_val = 32'hDEAD_1234;
         32'd8:   mem_val = 32'h5555_ABCD;
         32'd12:  mem_val = 32'hFFFF_0042;
         default: mem_val = 32'hBAD0_0000 | a;
      endcase
   endfunction

   assign mem_rd_data_w = mem_val(mem_addr_w);
   assign mem_rd_data_h = mem_val(mem_addr_h);

   mem_view_sequencer #(
      .BASE_ADDR (32'h0000_0004),
      .WORD_COUNT(3),
      .DWELL     (4),
      .WRAP      (1'b1)
   ) dut_w (
      .clk_1k     (clk_1k),
      .reset      (reset),
      .finish_btn (finish_btn),
      .step_btn   (step_btn),
      .auto_mode  (auto_mode),
      .pause      (pause),
      .cpu_mem_wr (cpu_mem_wr),
      .mem_rd_data(mem_rd_data_w),
      .disp_sel   (disp_sel_w),
      .mem_rd     (mem_rd_w),
      .mem_addr   (mem_addr_w),
      .disp_word  (disp_word_w),
      .word_idx   (word_idx_w),
      .at_end     (at_end_w),
      .collision  (collision_w)
   );

   mem_view_sequencer #(
      .BASE_ADDR (32'h0000_0004),
      .WORD_COUNT(3),
      .DWELL     (4),
      .WRAP      (1'b0)
   ) dut_h (
      .clk_1k     (clk_1k),
      .reset      (reset),
      .finish_btn (finish_btn),
      .step_btn   (step_btn),
      .auto_mode  (auto_mode),
      .pause      (pause),
      .cpu_mem_wr (cpu_mem_wr),
      .mem_rd_data(mem_rd_data_h),
      .disp_sel   (disp_sel_h),
      .mem_rd     (mem_rd_h),
      .mem_addr   (mem_addr_h),
      .disp_word  (disp_word_h),
      .word_idx   (word_idx_h),
      .at_end     (at_end_h),
      .collision  (collision_h)
   );

   initial begin
      clk_1k = 1'b0;
      forever #5 clk_1k = ~clk_1k;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic do_reset();
      finish_btn = 1'b0;
      step_btn   = 1'b0;
      auto_mode  = 1'b1;
      pause      = 1'b0;
      cpu_mem_wr = 1'b0;
      reset      = 1'b1;
      @(negedge clk_1k);
      @(negedge clk_1k);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      finish_btn = 1'b0;
      step_btn   = 1'b0;
      auto_mode  = 1'b1;
      pause      = 1'b0;
      cpu_mem_wr = 1'b0;
      reset      = 1'b1;
      @(negedge clk_1k);
      tests_run++; if (disp_sel_w !== 1'b0) begin tests_failed++; $display("FAIL reset_disp_sel got %b want 0", disp_sel_w); end
      tests_run++; if (mem_rd_w !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd got %b want 0", mem_rd_w); end
      tests_run++; if (mem_addr_w !== 32'd4) begin tests_failed++; $display("FAIL reset_mem_addr got %h want 4", mem_addr_w); end
      tests_run++; if (disp_word_w !== 16'd0) begin tests_failed++; $display("FAIL reset_disp_word got %h want 0", disp_word_w); end
      tests_run++; if (word_idx_w !== 16'd0) begin tests_failed++; $display("FAIL reset_word_idx got %0d want 0", word_idx_w); end
      tests_run++; if (at_end_w !== 1'b0) begin tests_failed++; $display("FAIL reset_at_end got %b want 0", at_end_w); end
      tests_run++; if (collision_w !== 1'b0) begin tests_failed++; $display("FAIL reset_collision got %b want 0", collision_w); end
      tests_run++; if (disp_sel_h !== 1'b0 || mem_addr_h !== 32'd4) begin tests_failed++; $display("FAIL reset_halt_inst got sel=%b addr=%h want 0/4", disp_sel_h, mem_addr_h); end
      @(negedge clk_1k);
      reset = 1'b0;
   endtask

   // Auto walk with DWELL=4, WORD_COUNT=3: each word held 6 cycles, wrap vs halt.
   task automatic test_auto_walk();
      int k;
      logic [15:0] exp_word;
      logic [31:0] exp_addr;
      logic [15:0] exp_idx;
      do_reset();
      auto_mode  = 1'b1;
      finish_btn = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk_1k);
         if (c <= 28) begin
            if (c < 5) exp_word = 16'h0000;
            else begin
               case (((c - 5) / 6) % 3)
                  0:       exp_word = 16'h1234;
                  1:       exp_word = 16'hABCD;
                  default: exp_word = 16'h0042;
               endcase
            end
            if (c < 3) begin
               exp_addr = 32'd4;
               exp_idx  = 16'd0;
            end else begin
               k = ((c - 3) / 6) % 3;
               exp_addr = 32'(4 + 4 * k);
               exp_idx  = 16'(k);
            end
            tests_run++; if (disp_word_w !== exp_word) begin tests_failed++; $display("FAIL auto_disp_word c=%0d got %h want %h", c, disp_word_w, exp_word); end
            tests_run++; if (mem_addr_w !== exp_addr) begin tests_failed++; $display("FAIL auto_mem_addr c=%0d got %h want %h", c, mem_addr_w, exp_addr); end
            tests_run++; if (word_idx_w !== exp_idx) begin tests_failed++; $display("FAIL auto_word_idx c=%0d got %0d want %0d", c, word_idx_w, exp_idx); end
            tests_run++; if (at_end_w !== (c >= 16 && c <= 20)) begin tests_failed++; $display("FAIL auto_at_end c=%0d got %b want %b", c, at_end_w, (c >= 16 && c <= 20)); end
         end
         if (c == 2) begin
            tests_run++; if (disp_sel_w !== 1'b0) begin tests_failed++; $display("FAIL auto_sel_before got %b want 0", disp_sel_w); end
         end
         if (c == 3 || c == 4) begin
            tests_run++; if (mem_rd_w !== 1'b1 || disp_sel_w !== 1'b1) begin tests_failed++; $display("FAIL auto_fetch c=%0d got rd=%b sel=%b want 1/1", c, mem_rd_w, disp_sel_w); end
         end
         if (c == 5) begin
            tests_run++; if (mem_rd_w !== 1'b0 || disp_sel_w !== 1'b1) begin tests_failed++; $display("FAIL auto_show got rd=%b sel=%b want 0/1", mem_rd_w, disp_sel_w); end
         end
         if (c >= 17) begin
            tests_run++; if (disp_word_h !== 16'h0042) begin tests_failed++; $display("FAIL halt_disp_word c=%0d got %h want 0042", c, disp_word_h); end
         end
         if (c >= 21) begin
            tests_run++; if (mem_rd_h !== 1'b0 || disp_sel_h !== 1'b1 || at_end_h !== 1'b1 || word_idx_h !== 16'd2) begin
               tests_failed++;
               $display("FAIL halt_state c=%0d got rd=%b sel=%b end=%b idx=%0d want 0/1/1/2", c, mem_rd_h, disp_sel_h, at_end_h, word_idx_h);
            end
         end
      end
      finish_btn = 1'b0;
   endtask

   // Manual stepping: a held button gives one advance, separate presses each advance.
   task automatic test_manual_step();
      do_reset();
      auto_mode  = 1'b0;
      finish_btn = 1'b1;
      repeat (8) @(negedge clk_1k);
      finish_btn = 1'b0;
      tests_run++; if (word_idx_w !== 16'd0 || disp_word_w !== 16'h1234) begin tests_failed++; $display("FAIL manual_start got idx=%0d word=%h want 0/1234", word_idx_w, disp_word_w); end
      step_btn = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_1k);
         if (c == 3) begin
            tests_run++; if (word_idx_w !== 16'd1 || mem_addr_w !== 32'd8) begin tests_failed++; $display("FAIL manual_step1 got idx=%0d addr=%h want 1/8", word_idx_w, mem_addr_w); end
         end
         if (c == 5) begin
            tests_run++; if (disp_word_w !== 16'hABCD) begin tests_failed++; $display("FAIL manual_word1 got %h want ABCD", disp_word_w); end
         end
      end
      step_btn = 1'b0;
      repeat (5) @(negedge clk_1k);
      tests_run++; if (word_idx_w !== 16'd1 || mem_rd_w !== 1'b0) begin tests_failed++; $display("FAIL manual_held_once got idx=%0d rd=%b want 1/0", word_idx_w, mem_rd_w); end
      step_btn = 1'b1;
      repeat (3) @(negedge clk_1k);
      step_btn = 1'b0;
      repeat (4) @(negedge clk_1k);
      tests_run++; if (word_idx_w !== 16'd2 || disp_word_w !== 16'h0042 || at_end_w !== 1'b1) begin
         tests_failed++;
         $display("FAIL manual_step2 got idx=%0d word=%h end=%b want 2/0042/1", word_idx_w, disp_word_w, at_end_w);
      end
      tests_run++; if (word_idx_h !== 16'd2) begin tests_failed++; $display("FAIL manual_halt_inst got idx=%0d want 2", word_idx_h); end
   endtask

   // Pause held for 10 SHOW cycles pushes the advance from cycle 9 to cycle 19.
   task automatic test_pause();
      do_reset();
      auto_mode  = 1'b1;
      finish_btn = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_1k);
         if (c == 9 || c == 18) begin
            tests_run++; if (word_idx_w !== 16'd0) begin tests_failed++; $display("FAIL pause_hold c=%0d got idx=%0d want 0", c, word_idx_w); end
         end
         if (c == 19) begin
            tests_run++; if (word_idx_w !== 16'd1 || mem_addr_w !== 32'd8) begin tests_failed++; $display("FAIL pause_advance got idx=%0d addr=%h want 1/8", word_idx_w, mem_addr_w); end
         end
         if (c == 3) finish_btn = 1'b0;
         if (c == 6) pause = 1'b1;
         if (c == 16) pause = 1'b0;
      end
   endtask

   // Second finish press while showing the last word; the restart beats the halt/advance.
   task automatic test_restart();
      do_reset();
      auto_mode  = 1'b1;
      finish_btn = 1'b1;
      for (int c = 1; c <= 23; c++) begin
         @(negedge clk_1k);
         if (c == 17 || c == 20) begin
            tests_run++; if (word_idx_w !== 16'd2 || word_idx_h !== 16'd2) begin tests_failed++; $display("FAIL restart_pre c=%0d got idx=%0d/%0d want 2/2", c, word_idx_w, word_idx_h); end
         end
         if (c == 21) begin
            tests_run++; if (word_idx_w !== 16'd0 || mem_addr_w !== 32'd4) begin tests_failed++; $display("FAIL restart_wrap got idx=%0d addr=%h want 0/4", word_idx_w, mem_addr_w); end
            tests_run++; if (word_idx_h !== 16'd0 || mem_addr_h !== 32'd4 || mem_rd_h !== 1'b1) begin
               tests_failed++;
               $display("FAIL restart_priority got idx=%0d addr=%h rd=%b want 0/4/1", word_idx_h, mem_addr_h, mem_rd_h);
            end
         end
         if (c == 23) begin
            tests_run++; if (disp_word_h !== 16'h1234) begin tests_failed++; $display("FAIL restart_word got %h want 1234", disp_word_h); end
         end
         if (c == 3) finish_btn = 1'b0;
         if (c == 18) finish_btn = 1'b1;
      end
      finish_btn = 1'b0;
   endtask

   // Collision flag and asynchronous reset in the middle of a walk.
   task automatic test_collision_reset();
      do_reset();
      auto_mode  = 1'b1;
      cpu_mem_wr = 1'b1;
      repeat (3) @(negedge clk_1k);
      cpu_mem_wr = 1'b0;
      tests_run++; if (collision_w !== 1'b0 || collision_h !== 1'b0) begin tests_failed++; $display("FAIL coll_idle got %b/%b want 0/0", collision_w, collision_h); end
      finish_btn = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_1k);
         if (c == 6) begin
            tests_run++; if (collision_w !== 1'b0) begin tests_failed++; $display("FAIL coll_before got %b want 0", collision_w); end
         end
         if (c == 7 || c == 12) begin
            tests_run++; if (collision_w !== 1'b1 || collision_h !== 1'b1) begin tests_failed++; $display("FAIL coll_sticky c=%0d got %b/%b want 1/1", c, collision_w, collision_h); end
         end
         cpu_mem_wr = (c == 6);
      end
      #2 reset = 1'b1;
      #1;
      tests_run++; if (disp_sel_w !== 1'b0 || mem_rd_w !== 1'b0) begin tests_failed++; $display("FAIL async_rst_grant got sel=%b rd=%b want 0/0", disp_sel_w, mem_rd_w); end
      tests_run++; if (mem_addr_w !== 32'd4 || word_idx_w !== 16'd0) begin tests_failed++; $display("FAIL async_rst_addr got addr=%h idx=%0d want 4/0", mem_addr_w, word_idx_w); end
      tests_run++; if (disp_word_w !== 16'd0 || at_end_w !== 1'b0) begin tests_failed++; $display("FAIL async_rst_word got word=%h end=%b want 0/0", disp_word_w, at_end_w); end
      tests_run++; if (collision_w !== 1'b0 || collision_h !== 1'b0) begin tests_failed++; $display("FAIL async_rst_coll got %b/%b want 0/0", collision_w, collision_h); end
      @(negedge clk_1k);
      finish_btn = 1'b0;
      reset      = 1'b0;
      repeat (4) @(negedge clk_1k);
      tests_run++; if (disp_sel_w !== 1'b0 || word_idx_w !== 16'd0) begin tests_failed++; $display("FAIL post_rst_idle got sel=%b idx=%0d want 0/0", disp_sel_w, word_idx_w); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_auto_walk();
      test_manual_step();
      test_pause();
      test_restart();
      test_collision_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
